// File: rtl/time_keeper.sv
// time_keeper: BCD hh:mm:ss clock with RUN / SET_HR / SET_MIN modes.
// slow_clk supplies TICKS_PER_SEC rising edges per second. Every asynchronous
// input passes through a two-flop synchronizer, and a third flop detects edges.
// Optional build macro TWELVE_HOUR_EN selects 12-hour mode (hours 01..12 plus a
// PM flag). When the macro is undefined, hours run 00..23 and pm stays 0.
module time_keeper #(
    parameter int TICKS_PER_SEC = 4
) (
    input  logic       clk_in,
    input  logic       rst_n,
    input  logic       slow_clk,
    input  logic       mode_btn,
    input  logic       up_btn,
    output logic [7:0] hr_bcd,
    output logic [7:0] min_bcd,
    output logic [7:0] sec_bcd,
    output logic [1:0] set_mode,
    output logic       blink,
    output logic       pm
);

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        SET_HR  = 2'b01,
        SET_MIN = 2'b10
    } mode_e;

`ifdef TWELVE_HOUR_EN
    localparam logic [7:0] HR_RESET = 8'h12;
`else
    localparam logic [7:0] HR_RESET = 8'h00;
`endif
    localparam logic [3:0] CNT_LAST = 4'(TICKS_PER_SEC - 1);

    // Bit 0 is the first sync stage, bit 1 the second, bit 2 the previous synced value.
    logic [2:0] slow_sh_q, mode_sh_q, up_sh_q;
    // fill_q marks when the sync chain holds real samples. armed_q is set once
    // slow_clk has been seen low, so a level that is already high at reset
    // release does not produce a tick.
    logic [1:0] fill_q;
    logic       armed_q;
    logic       tick, mode_edge, up_edge, up_ev, tick_ev;

    mode_e      mode_q, mode_d;
    logic [7:0] hr_q, hr_d, min_q, min_d, sec_q, sec_d;
    logic [3:0] cnt_q, cnt_d;
    logic       blink_q, blink_d, pm_q, pm_d;

    // Two-digit BCD increment with no range wrap. The caller handles wrapping.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
        else                return {v[7:4], v[3:0] + 4'd1};
    endfunction

    // Hour step over the legal hour range of the selected build.
    function automatic logic [7:0] hr_inc(input logic [7:0] v);
`ifdef TWELVE_HOUR_EN
        return (v == 8'h12) ? 8'h01 : bcd_inc(v);
`else
        return (v == 8'h23) ? 8'h00 : bcd_inc(v);
`endif
    endfunction

    // Synchronize the asynchronous inputs and keep the previous value for edge detection.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            slow_sh_q <= '0;
            mode_sh_q <= '0;
            up_sh_q   <= '0;
            fill_q    <= '0;
            armed_q   <= 1'b0;
        end else begin
            slow_sh_q <= {slow_sh_q[1:0], slow_clk};
            mode_sh_q <= {mode_sh_q[1:0], mode_btn};
            up_sh_q   <= {up_sh_q[1:0], up_btn};
            fill_q    <= {fill_q[0], 1'b1};
            armed_q   <= armed_q | (fill_q[1] & ~slow_sh_q[1]);
        end
    end

    assign tick      = armed_q & slow_sh_q[1] & ~slow_sh_q[2];
    assign mode_edge = mode_sh_q[1] & ~mode_sh_q[2];
    assign up_edge   = up_sh_q[1] & ~up_sh_q[2];
    // Event priority: mode beats up, and up beats tick. A lower-priority event in the same cycle is dropped.
    assign up_ev     = up_edge & ~mode_edge;
    assign tick_ev   = tick & ~mode_edge & ~up_edge;

    // Next-state logic for the mode FSM, the time fields and blink.
    always_comb begin
        mode_d  = mode_q;
        hr_d    = hr_q;
        min_d   = min_q;
        sec_d   = sec_q;
        cnt_d   = cnt_q;
        blink_d = blink_q;
        pm_d    = pm_q;
        case (mode_q)
            RUN: begin
                if (mode_edge) begin
                    mode_d  = SET_HR;
                    blink_d = 1'b0;
                end else if (tick_ev) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d = 4'd0;
                        if (sec_q == 8'h59) begin
                            sec_d = 8'h00;
                            if (min_q == 8'h59) begin
                                min_d = 8'h00;
                                hr_d  = hr_inc(hr_q);
`ifdef TWELVE_HOUR_EN
                                if (hr_q == 8'h11) pm_d = ~pm_q;
`endif
                            end else begin
                                min_d = bcd_inc(min_q);
                            end
                        end else begin
                            sec_d = bcd_inc(sec_q);
                        end
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            SET_HR: begin
                if (mode_edge) begin
                    mode_d  = SET_MIN;
                    blink_d = 1'b0;
                end else if (up_ev || (tick_ev && up_sh_q[1])) begin
                    hr_d = hr_inc(hr_q);
`ifdef TWELVE_HOUR_EN
                    if (hr_q == 8'h11) pm_d = ~pm_q;
`endif
                end
                if (!mode_edge && tick_ev) blink_d = ~blink_q;
            end
            default: begin
                if (mode_edge) begin
                    mode_d  = RUN;
                    sec_d   = 8'h00;
                    cnt_d   = 4'd0;
                    blink_d = 1'b0;
                end else if (up_ev || (tick_ev && up_sh_q[1])) begin
                    min_d = (min_q == 8'h59) ? 8'h00 : bcd_inc(min_q);
                end
                if (!mode_edge && tick_ev) blink_d = ~blink_q;
            end
        endcase
    end

    // State registers. Reset abandons any set or cascade operation in progress.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            mode_q  <= RUN;
            hr_q    <= HR_RESET;
            min_q   <= 8'h00;
            sec_q   <= 8'h00;
            cnt_q   <= 4'd0;
            blink_q <= 1'b0;
            pm_q    <= 1'b0;
        end else begin
            mode_q  <= mode_d;
            hr_q    <= hr_d;
            min_q   <= min_d;
            sec_q   <= sec_d;
            cnt_q   <= cnt_d;
            blink_q <= blink_d;
            pm_q    <= pm_d;
        end
    end

    assign hr_bcd   = hr_q;
    assign min_bcd  = min_q;
    assign sec_bcd  = sec_q;
    assign set_mode = mode_q;
    assign blink    = blink_q;
    assign pm       = pm_q;

endmodule

// File: tb/tb_time_keeper.sv
// Testbench for time_keeper. Stimulus pushes the expected visible state into a
// queue; a monitor pops and compares each time the DUT outputs change.
module tb_time_keeper;
    localparam int TPS = 4;

    logic       clk = 1'b0, rst_n = 1'b0, slow_clk = 1'b0, mode_btn = 1'b0, up_btn = 1'b0;
    logic [7:0] hr_bcd, min_bcd, sec_bcd;
    logic [1:0] set_mode;
    logic       blink, pm;

    time_keeper #(.TICKS_PER_SEC(TPS)) dut (
        .clk_in(clk), .rst_n(rst_n), .slow_clk(slow_clk), .mode_btn(mode_btn),
        .up_btn(up_btn), .hr_bcd(hr_bcd), .min_bcd(min_bcd), .sec_bcd(sec_bcd),
        .set_mode(set_mode), .blink(blink), .pm(pm)
    );

    always #5 clk = ~clk;

    typedef logic [27:0] snap_t; // {hr, min, sec, mode, blink, pm}
    snap_t exp_q[$];
    snap_t last_seen, mon_cur, mon_exp;
    int    checks = 0, errors = 0;
    bit    mon_en = 1'b0;

    // Reference model: plain integer clock fields.
    int m_h, m_m, m_s, m_cnt, m_mode;
    bit m_blink, m_pm, m_up_held;

    function automatic logic [7:0] to_bcd(input int v);
        logic [7:0] r;
        r[7:4] = 4'(v / 10);
        r[3:0] = 4'(v % 10);
        return r;
    endfunction

    function automatic snap_t model_snap();
        return {to_bcd(m_h), to_bcd(m_m), to_bcd(m_s), 2'(m_mode), m_blink, m_pm};
    endfunction

    function automatic snap_t dut_snap();
        return {hr_bcd, min_bcd, sec_bcd, set_mode, blink, pm};
    endfunction

    function automatic string fmt(input snap_t s);
        return $sformatf("%h:%h:%h mode=%0d blink=%0b pm=%0b",
                         s[27:20], s[19:12], s[11:4], s[3:2], s[1], s[0]);
    endfunction

    task automatic model_reset();
`ifdef TWELVE_HOUR_EN
        m_h = 12;
`else
        m_h = 0;
`endif
        m_m = 0; m_s = 0; m_cnt = 0; m_mode = 0; m_blink = 0; m_pm = 0; m_up_held = 0;
    endtask

    task automatic hr_step();
`ifdef TWELVE_HOUR_EN
        if (m_h == 11) m_pm = ~m_pm;
        m_h = (m_h % 12) + 1;
`else
        m_h = (m_h + 1) % 24;
`endif
    endtask

    task automatic model_tick();
        if (m_mode == 0) begin
            m_cnt++;
            if (m_cnt == TPS) begin
                m_cnt = 0;
                m_s++;
                if (m_s == 60) begin
                    m_s = 0;
                    m_m++;
                    if (m_m == 60) begin
                        m_m = 0;
                        hr_step();
                    end
                end
                exp_q.push_back(model_snap());
            end
        end else begin
            m_blink = ~m_blink;
            if (m_up_held) begin
                if (m_mode == 1) hr_step();
                else             m_m = (m_m + 1) % 60;
            end
            exp_q.push_back(model_snap());
        end
    endtask

    task automatic model_mode();
        if (m_mode == 2) begin
            m_s = 0;
            m_cnt = 0;
        end
        m_mode = (m_mode + 1) % 3;
        m_blink = 0;
        exp_q.push_back(model_snap());
    endtask

    task automatic model_up();
        if (m_mode == 1) begin
            hr_step();
            exp_q.push_back(model_snap());
        end else if (m_mode == 2) begin
            m_m = (m_m + 1) % 60;
            exp_q.push_back(model_snap());
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_tick();
        slow_clk = 1'b1; model_tick(); cyc(4);
        slow_clk = 1'b0; cyc(4);
    endtask

    task automatic press_mode();
        mode_btn = 1'b1; model_mode(); cyc(4);
        mode_btn = 1'b0; cyc(4);
    endtask

    task automatic press_up();
        up_btn = 1'b1; model_up(); cyc(4);
        up_btn = 1'b0; cyc(4);
    endtask

    task automatic hold_up_ticks(input int k);
        up_btn = 1'b1; model_up(); m_up_held = 1'b1; cyc(4);
        repeat (k) do_tick();
        up_btn = 1'b0; m_up_held = 1'b0; cyc(4);
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d pending updates, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_now(input string name);
        checks++;
        if (dut_snap() !== model_snap()) begin
            errors++;
            $display("FAIL %s: got %s required %s", name, fmt(dut_snap()), fmt(model_snap()));
        end else begin
            $display("chk %s: %s", name, fmt(dut_snap()));
        end
    endtask

    // Monitor: every change of the output bundle must match the next queued expectation.
    always @(negedge clk) begin
        if (mon_en) begin
            mon_cur = dut_snap();
            if (mon_cur !== last_seen) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_update: got %s required %s", fmt(mon_cur), fmt(last_seen));
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (mon_cur !== mon_exp) begin
                        errors++;
                        $display("FAIL update: got %s required %s", fmt(mon_cur), fmt(mon_exp));
                    end else begin
                        $display("upd: %s", fmt(mon_cur));
                    end
                end
                last_seen = mon_cur;
            end
        end
    end

    initial begin
        model_reset();
        cyc(3);
        check_now("reset");
        rst_n = 1'b1;
        cyc(5);
        last_seen = model_snap();
        mon_en = 1'b1;

        // One second of ticks, then check tick-to-output latency on the fourth edge.
        repeat (TPS - 1) do_tick();
        slow_clk = 1'b1;
        model_tick();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (sec_bcd !== 8'h00) begin
            errors++;
            $display("FAIL tick_latency_early: sec %h required 00", sec_bcd);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (sec_bcd !== 8'h01) begin
            errors++;
            $display("FAIL tick_latency: sec %h required 01", sec_bcd);
        end
        cyc(3);
        slow_clk = 1'b0;
        cyc(4);
        wait_drain("first_second");

        // Run to sec 37, then set the hour with auto-repeat wrapping through midnight.
        repeat (36 * TPS) do_tick();
        wait_drain("run37");
        press_mode();
        repeat (20) press_up();
        wait_drain("hr20");
        check_now("hr20");
        hold_up_ticks(10);
        wait_drain("hold");
        check_now("hold_wrap");
        repeat (16) press_up();
        press_mode();
        repeat (60) press_up();
        wait_drain("min_wrap");
        check_now("min_wrap_no_carry");
        repeat (59) press_up();
        press_mode();
        wait_drain("to_run");
        check_now("to_run_sec_clear");

        // Midnight cascade.
        repeat (59 * TPS + TPS - 1) do_tick();
        wait_drain("preload");
        check_now("preload_235959");
        do_tick();
        wait_drain("cascade");
        check_now("cascade");

        // mode_edge and tick in the same cycle: only the mode change takes effect.
        repeat (5 * TPS + TPS - 1) do_tick();
        wait_drain("sec05");
        mode_btn = 1'b1;
        slow_clk = 1'b1;
        model_mode();
        cyc(4);
        mode_btn = 1'b0;
        slow_clk = 1'b0;
        cyc(4);
        wait_drain("mode_vs_tick");
        check_now("mode_vs_tick");

        // Short asynchronous reset during SET_HR while slow_clk is high.
        slow_clk = 1'b1;
        model_tick();
        cyc(4);
        wait_drain("pre_reset");
        mon_en = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b0;
        #0.5;
        model_reset();
        check_now("async_reset");
        #0.5 rst_n = 1'b1;
        last_seen = model_snap();
        mon_en = 1'b1;
        cyc(20);
        wait_drain("no_tick_high");
        slow_clk = 1'b0;
        cyc(4);
        repeat (TPS) do_tick();
        wait_drain("post_reset");
        check_now("post_reset_second");

        // Random stimulus against the reference model.
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0: do_tick();
                1: press_up();
                2: press_mode();
                default: hold_up_ticks(int'($urandom_range(1, 4)));
            endcase
        end
        wait_drain("random");
        check_now("random_final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Time limit so the bench always terminates.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end
endmodule
